// File: rtl/guess_input_pkg.sv
// Shared definitions for the binary-game player input path: guess width,
// capture FSM states and the default debounce interval.
package guess_input_pkg;

  localparam int GUESS_WIDTH             = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Wide enough to hold DEBOUNCE_CYCLES itself, so the counter never wraps.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/guess_input_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the output follows
// the input only after it has held a new level for DEBOUNCE_CYCLES cycles.
module debouncer
  import guess_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample matching the current level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/guess_input.sv
// Player-side capture: synchronises the switches, debounces the submit button
// and offers each clean press's switch value over a valid/ready handshake.
module guess_input
  import guess_input_pkg::*;
#(
  parameter int WIDTH           = GUESS_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn,
  input  logic             guess_ready,
  output logic [WIDTH-1:0] guess,
  output logic             guess_valid,
  output logic             btn_level
);

  logic [WIDTH-1:0] sw_meta_q;
  logic [WIDTH-1:0] sw_s_q;
  logic             btn_level_w;
  logic             btn_level_q;
  logic             press;
  state_e           state_q;
  logic [WIDTH-1:0] guess_q;
  logic             valid_q;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk  (clk),
    .rst  (rst),
    .din  (btn),
    .dout (btn_level_w)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_meta_q   <= '0;
      sw_s_q      <= '0;
      btn_level_q <= 1'b0;
    end else begin
      sw_meta_q   <= sw;
      sw_s_q      <= sw_meta_q;
      btn_level_q <= btn_level_w;
    end
  end

  // Rising edge of the debounced level only; a held button yields one pulse.
  assign press = btn_level_w & ~btn_level_q;

  // Presses arriving while a guess is pending are dropped, not queued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      guess_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            guess_q <= sw_s_q;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (guess_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign guess       = guess_q;
  assign guess_valid = valid_q;
  assign btn_level   = btn_level_w;

endmodule

// File: tb/tb_guess_input.sv
// Bench for guess_input: directed scenarios plus random button/switch/ready
// traffic, checked against a window-based behavioural model and a scoreboard.
module tb_guess_input;

  localparam int D = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] sw  = '0;
  logic         btn = 1'b0;
  logic         rdy = 1'b0;
  logic [W-1:0] guess;
  logic         guess_valid;
  logic         btn_level;

  int checks = 0;
  int fails  = 0;
  int xfer_cnt = 0;
  bit lvl_seen = 0;

  // reference model state
  bit           m_b1, m_b2;
  logic [W-1:0] m_sw1, m_sw2;
  bit           m_level, m_level_q, m_valid;
  logic [W-1:0] m_guess;
  bit           m_hist[$];
  logic [W-1:0] exp_q[$];

  guess_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .btn         (btn),
    .guess_ready (rdy),
    .guess       (guess),
    .guess_valid (guess_valid),
    .btn_level   (btn_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the level flips once the last D synchronised samples all differ from it.
  always @(posedge clk) begin : model
    bit press, nl, all_diff;
    if (!rst) begin
      if (m_valid && !rdy && exp_q.size() > 0) void'(exp_q.pop_back());
      m_b1 = 0; m_b2 = 0; m_sw1 = '0; m_sw2 = '0;
      m_level = 0; m_level_q = 0; m_valid = 0; m_guess = '0;
      m_hist.delete();
    end else begin
      press = m_level & ~m_level_q;
      nl    = m_level;
      m_hist.push_back(m_b2);
      while (m_hist.size() > D) void'(m_hist.pop_front());
      if (m_hist.size() == D) begin
        all_diff = 1;
        for (int k = 0; k < D; k++) if (m_hist[k] == m_level) all_diff = 0;
        if (all_diff) begin
          nl = ~m_level;
          m_hist.delete();
        end
      end
      if (!m_valid) begin
        if (press) begin
          m_valid = 1;
          m_guess = m_sw2;
          exp_q.push_back(m_sw2);
        end
      end else if (rdy) begin
        m_valid = 0;
      end
      m_level_q = m_level;
      m_level   = nl;
      m_b2 = m_b1;  m_b1 = btn;
      m_sw2 = m_sw1; m_sw1 = sw;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    chk("guess_valid", int'(guess_valid), int'(m_valid));
    chk("guess", int'(guess), int'(m_guess));
    chk("btn_level", int'(btn_level), int'(m_level));
    if (btn_level) lvl_seen = 1;
    if (guess_valid && rdy) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", 1, 0);
      end else begin
        chk("transfer_data", int'(guess), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      edges++;
      if (guess_valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int lat, x0;
    // 1: reset holds outputs low even with the button pressed
    rst = 0; btn = 1; sw = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_valid", int'(guess_valid), 0);
      chk("rst_guess", int'(guess), 0);
      chk("rst_level", int'(btn_level), 0);
    end
    rst = 1; btn = 0; sw = '0;
    step(12);

    // 2: clean press with ready already high
    sw = 8'hA5; rdy = 1; btn = 1;
    step(1);
    wait_valid(lat);
    chk("press_latency", lat, 6);
    chk("press_guess", int'(guess), 8'hA5);
    step(1);
    chk("one_cycle_valid", int'(guess_valid), 0);
    btn = 0;
    step(10);

    // 3: bounce shorter than the debounce interval
    lvl_seen = 0; x0 = xfer_cnt;
    for (int i = 0; i < 12; i++) begin
      btn = (i % 2 == 0);
      step(2);
    end
    btn = 0;
    step(10);
    chk("bounce_level_seen", int'(lvl_seen), 0);
    chk("bounce_transfers", xfer_cnt - x0, 0);

    // 4: guess frozen while not ready
    rdy = 0; sw = 8'hA5; btn = 1;
    wait_valid(lat);
    sw = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_guess", int'(guess), 8'hA5);
      chk("hold_valid", int'(guess_valid), 1);
    end
    rdy = 1;
    step(1);
    chk("accept_drop", int'(guess_valid), 0);
    rdy = 0;

    // 5: press during HOLD is discarded; held button does not resubmit
    btn = 0; step(10);
    sw = 8'h11; btn = 1;
    wait_valid(lat);
    btn = 0; step(10);
    btn = 1; step(10);
    x0 = xfer_cnt;
    rdy = 1;
    step(20);
    chk("held_no_resubmit", xfer_cnt - x0, 1);
    btn = 0; step(10);
    sw = 8'h3C; btn = 1;
    wait_valid(lat);
    chk("fresh_guess", int'(guess), 8'h3C);
    step(1);
    chk("fresh_transfers", xfer_cnt - x0, 2);
    btn = 0; step(10);

    // 6: reset mid-HOLD drops the pending guess
    rdy = 0; sw = 8'h5A; btn = 1;
    wait_valid(lat);
    btn = 0; step(2);
    rst = 0; step(1);
    chk("midrst_valid", int'(guess_valid), 0);
    chk("midrst_guess", int'(guess), 0);
    rst = 1; rdy = 1; x0 = xfer_cnt;
    step(20);
    chk("midrst_no_xfer", xfer_cnt - x0, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      btn = $urandom_range(0, 1);
      sw  = W'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) != 0);
      if (!rst) step(1);
      rst = 1;
      step($urandom_range(1, 8));
    end

    rdy = 1; btn = 0;
    step(20);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
